// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and constants for the line-memory arbiter
package mem_arb_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int LINE_W_DEF = 256;

    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_I    = 2'b01;
    localparam logic [1:0] GNT_D    = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        BUSY_I,
        BUSY_D,
        DONE_I,
        DONE_D
    } state_e;

endpackage

// File: rtl/mem_arb_picker.sv
// rtl/mem_arb_picker.sv - winner select between icache and dcache requests
// MEM_ARB_RR_EN selects round-robin; otherwise dcache has fixed priority.
module mem_arb_picker (
    input  logic i_req_i,
    input  logic d_req_i,
`ifdef MEM_ARB_RR_EN
    input  logic last_d_i,
`endif
    output logic pick_i_o,
    output logic pick_d_o
);

    always_comb begin
`ifdef MEM_ARB_RR_EN
        // On a tie the requester that did not win last time goes first.
        pick_d_o = d_req_i && (!i_req_i || !last_d_i);
`else
        pick_d_o = d_req_i;
`endif
        pick_i_o = i_req_i && !pick_d_o;
    end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - shares the off-chip line-memory port between icache and dcache
// Define MEM_ARB_RR_EN for round-robin arbitration instead of fixed dcache priority.
module mem_arbiter #(
    parameter int ADDR_W         = mem_arb_pkg::ADDR_W_DEF,
    parameter int LINE_W         = mem_arb_pkg::LINE_W_DEF,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              i_req_i,
    input  logic [ADDR_W-1:0] i_addr_i,
    output logic              i_ack_o,
    output logic [LINE_W-1:0] i_data_o,
    input  logic              d_req_i,
    input  logic              d_write_i,
    input  logic [ADDR_W-1:0] d_addr_i,
    input  logic [LINE_W-1:0] d_data_i,
    output logic              d_ack_o,
    output logic [LINE_W-1:0] d_data_o,
    output logic              mem_enable_o,
    output logic              mem_write_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [LINE_W-1:0] mem_data_o,
    input  logic [LINE_W-1:0] mem_data_i,
    input  logic              mem_ack_i,
    output logic [1:0]        grant_o,
    output logic              timeout_o
);
    import mem_arb_pkg::*;

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              write_q, write_d;
    logic [LINE_W-1:0] wdata_q, wdata_d;
    logic [LINE_W-1:0] i_data_q, i_data_d;
    logic [LINE_W-1:0] d_data_q, d_data_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              timeout_q, timeout_d;
    logic              mem_enable_q, mem_enable_d;
    logic              mem_write_q, mem_write_d;
    logic [1:0]        grant_q, grant_d;
    logic              i_ack_q, i_ack_d;
    logic              d_ack_q, d_ack_d;
    logic              pick_i, pick_d;

`ifdef MEM_ARB_RR_EN
    logic last_d_q, last_d_d;

    mem_arb_picker u_picker (
        .i_req_i  (i_req_i),
        .d_req_i  (d_req_i),
        .last_d_i (last_d_q),
        .pick_i_o (pick_i),
        .pick_d_o (pick_d)
    );

    always_comb begin
        last_d_d = last_d_q;
        if (state_q == IDLE && (pick_i || pick_d)) begin
            last_d_d = pick_d;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            last_d_q <= 1'b0;
        end else begin
            last_d_q <= last_d_d;
        end
    end
`else
    mem_arb_picker u_picker (
        .i_req_i  (i_req_i),
        .d_req_i  (d_req_i),
        .pick_i_o (pick_i),
        .pick_d_o (pick_d)
    );
`endif

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        write_d   = write_q;
        wdata_d   = wdata_q;
        i_data_d  = i_data_q;
        d_data_d  = d_data_q;
        cnt_d     = '0;
        timeout_d = timeout_q;
        case (state_q)
            IDLE: begin
                if (pick_d) begin
                    state_d = BUSY_D;
                    addr_d  = d_addr_i;
                    write_d = d_write_i;
                    wdata_d = d_data_i;
                end else if (pick_i) begin
                    state_d = BUSY_I;
                    addr_d  = i_addr_i;
                    write_d = 1'b0;
                    wdata_d = '0;
                end
            end
            BUSY_I, BUSY_D: begin
                if (mem_ack_i) begin
                    if (state_q == BUSY_I) begin
                        state_d  = DONE_I;
                        i_data_d = mem_data_i;
                    end else begin
                        state_d  = DONE_D;
                        d_data_d = mem_data_i;
                    end
                end else begin
                    // Counter freezes once the sticky flag is up so it never wraps.
                    cnt_d = timeout_q ? cnt_q : cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        timeout_d = 1'b1;
                    end
                end
            end
            DONE_I, DONE_D: state_d = IDLE;
            default:        state_d = IDLE;
        endcase

        mem_enable_d = (state_d == BUSY_I) || (state_d == BUSY_D);
        mem_write_d  = (state_d == BUSY_D) && write_d;
        grant_d      = (state_d == BUSY_I) ? GNT_I :
                       (state_d == BUSY_D) ? GNT_D : GNT_NONE;
        i_ack_d      = (state_d == DONE_I);
        d_ack_d      = (state_d == DONE_D);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            write_q      <= 1'b0;
            wdata_q      <= '0;
            i_data_q     <= '0;
            d_data_q     <= '0;
            cnt_q        <= '0;
            timeout_q    <= 1'b0;
            mem_enable_q <= 1'b0;
            mem_write_q  <= 1'b0;
            grant_q      <= GNT_NONE;
            i_ack_q      <= 1'b0;
            d_ack_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            write_q      <= write_d;
            wdata_q      <= wdata_d;
            i_data_q     <= i_data_d;
            d_data_q     <= d_data_d;
            cnt_q        <= cnt_d;
            timeout_q    <= timeout_d;
            mem_enable_q <= mem_enable_d;
            mem_write_q  <= mem_write_d;
            grant_q      <= grant_d;
            i_ack_q      <= i_ack_d;
            d_ack_q      <= d_ack_d;
        end
    end

    assign i_ack_o      = i_ack_q;
    assign i_data_o     = i_data_q;
    assign d_ack_o      = d_ack_q;
    assign d_data_o     = d_data_q;
    assign mem_enable_o = mem_enable_q;
    assign mem_write_o  = mem_write_q;
    assign mem_addr_o   = addr_q;
    assign mem_data_o   = wdata_q;
    assign grant_o      = grant_q;
    assign timeout_o    = timeout_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic         i_req_i;
    logic [31:0]  i_addr_i;
    logic         i_ack_o;
    logic [255:0] i_data_o;
    logic         d_req_i;
    logic         d_write_i;
    logic [31:0]  d_addr_i;
    logic [255:0] d_data_i;
    logic         d_ack_o;
    logic [255:0] d_data_o;
    logic         mem_enable_o;
    logic         mem_write_o;
    logic [31:0]  mem_addr_o;
    logic [255:0] mem_data_o;
    logic [255:0] mem_data_i;
    logic         mem_ack_i;
    logic [1:0]   grant_o;
    logic         timeout_o;

    int total = 0;
    int bad   = 0;
    bit rr;
    bit first_d;

    always #5 clk_i = ~clk_i;

    mem_arbiter #(
        .ADDR_W         (32),
        .LINE_W         (256),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .i_req_i      (i_req_i),
        .i_addr_i     (i_addr_i),
        .i_ack_o      (i_ack_o),
        .i_data_o     (i_data_o),
        .d_req_i      (d_req_i),
        .d_write_i    (d_write_i),
        .d_addr_i     (d_addr_i),
        .d_data_i     (d_data_i),
        .d_ack_o      (d_ack_o),
        .d_data_o     (d_data_o),
        .mem_enable_o (mem_enable_o),
        .mem_write_o  (mem_write_o),
        .mem_addr_o   (mem_addr_o),
        .mem_data_o   (mem_data_o),
        .mem_data_i   (mem_data_i),
        .mem_ack_i    (mem_ack_i),
        .grant_o      (grant_o),
        .timeout_o    (timeout_o)
    );

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
`ifdef MEM_ARB_RR_EN
        rr = 1'b1;
`else
        rr = 1'b0;
`endif
        rst_i = 1'b1;
        i_req_i = 0; i_addr_i = '0;
        d_req_i = 0; d_write_i = 0; d_addr_i = '0; d_data_i = '0;
        mem_data_i = '0; mem_ack_i = 0;
        #12;
        chk("rst_en", mem_enable_o, 0);
        chk("rst_wr", mem_write_o, 0);
        chk("rst_gnt", grant_o, 0);
        chk("rst_iack", i_ack_o, 0);
        chk("rst_dack", d_ack_o, 0);
        chk("rst_to", timeout_o, 0);
        chk("rst_idata", i_data_o, 0);
        @(negedge clk_i);
        rst_i = 1'b0;
        tick;

        // icache fill, memory answers in cycle 10
        i_req_i = 1; i_addr_i = 32'h0000_0400;
        chk("t1_gnt0", grant_o, 0);
        tick;
        for (int c = 1; c <= 10; c++) begin
            chk("t1_en", mem_enable_o, 1);
            chk("t1_wr", mem_write_o, 0);
            chk("t1_addr", mem_addr_o, 32'h400);
            chk("t1_gnt", grant_o, 2'b01);
            if (c < 10) tick;
        end
        mem_ack_i = 1; mem_data_i = 256'hA5;
        tick;
        mem_ack_i = 0; mem_data_i = '0;
        chk("t1_iack", i_ack_o, 1);
        chk("t1_idata", i_data_o, 256'hA5);
        chk("t1_ddata", d_data_o, 0);
        chk("t1_en_off", mem_enable_o, 0);
        chk("t1_gnt_off", grant_o, 0);
        chk("t1_to", timeout_o, 1);
        i_req_i = 0;
        tick;
        chk("t1_iack_pulse", i_ack_o, 0);
        chk("t1_idata_hold", i_data_o, 256'hA5);
        tick;
        chk("t1_no_regrant", mem_enable_o, 0);

        // dcache write-back; request data changes after latching
        d_req_i = 1; d_write_i = 1; d_addr_i = 32'h0000_1000; d_data_i = 256'h1234;
        tick;
        chk("t2_en", mem_enable_o, 1);
        chk("t2_wr", mem_write_o, 1);
        chk("t2_addr", mem_addr_o, 32'h1000);
        chk("t2_data", mem_data_o, 256'h1234);
        chk("t2_gnt", grant_o, 2'b10);
        d_data_i = 256'hBAD;
        tick;
        tick;
        chk("t2_data_hold", mem_data_o, 256'h1234);
        chk("t2_wr_hold", mem_write_o, 1);
        mem_ack_i = 1;
        tick;
        mem_ack_i = 0;
        chk("t2_dack", d_ack_o, 1);
        chk("t2_iack", i_ack_o, 0);
        chk("t2_en_off", mem_enable_o, 0);
        chk("t2_wr_off", mem_write_o, 0);
        chk("t2_idata_hold", i_data_o, 256'hA5);
        d_req_i = 0; d_write_i = 0;
        tick;
        chk("t2_dack_pulse", d_ack_o, 0);

        // simultaneous requests; last winner is dcache here
        first_d = !rr;
        i_req_i = 1; i_addr_i = 32'h2000;
        d_req_i = 1; d_addr_i = 32'h3000;
        tick;
        chk("t3_gnt1", grant_o, first_d ? 2'b10 : 2'b01);
        chk("t3_addr1", mem_addr_o, first_d ? 32'h3000 : 32'h2000);
        mem_ack_i = 1; mem_data_i = first_d ? 256'hDD : 256'hCC;
        tick;
        mem_ack_i = 0;
        chk("t3_dack1", d_ack_o, first_d);
        chk("t3_iack1", i_ack_o, !first_d);
        if (first_d) d_req_i = 0; else i_req_i = 0;
        tick;
        chk("t3_idle", grant_o, 0);
        tick;
        chk("t3_gnt2", grant_o, first_d ? 2'b01 : 2'b10);
        chk("t3_addr2", mem_addr_o, first_d ? 32'h2000 : 32'h3000);
        mem_ack_i = 1; mem_data_i = first_d ? 256'hCC : 256'hDD;
        tick;
        mem_ack_i = 0;
        chk("t3_dack2", d_ack_o, !first_d);
        chk("t3_iack2", i_ack_o, first_d);
        chk("t3_idata", i_data_o, 256'hCC);
        chk("t3_ddata", d_data_o, 256'hDD);
        i_req_i = 0; d_req_i = 0;
        tick;

        // dcache re-requests right after its ack while icache waits
        d_req_i = 1; d_addr_i = 32'h4000;
        tick;
        chk("t4_gnt_d", grant_o, 2'b10);
        i_req_i = 1; i_addr_i = 32'h6000;
        mem_ack_i = 1; mem_data_i = 256'hEE;
        tick;
        mem_ack_i = 0;
        chk("t4_dack", d_ack_o, 1);
        chk("t4_ddata", d_data_o, 256'hEE);
        d_req_i = 0;
        tick;
        chk("t4_idle", grant_o, 0);
        d_req_i = 1; d_addr_i = 32'h5000;
        tick;
        chk("t4_gnt_a", grant_o, rr ? 2'b01 : 2'b10);
        chk("t4_addr_a", mem_addr_o, rr ? 32'h6000 : 32'h5000);
        mem_ack_i = 1; mem_data_i = 256'h11;
        tick;
        mem_ack_i = 0;
        chk("t4_ack_a", rr ? i_ack_o : d_ack_o, 1);
        if (rr) i_req_i = 0; else d_req_i = 0;
        tick;
        chk("t4_idle2", grant_o, 0);
        tick;
        chk("t4_gnt_b", grant_o, rr ? 2'b10 : 2'b01);
        chk("t4_addr_b", mem_addr_o, rr ? 32'h5000 : 32'h6000);
        mem_ack_i = 1; mem_data_i = 256'h22;
        tick;
        mem_ack_i = 0;
        chk("t4_ack_b", rr ? d_ack_o : i_ack_o, 1);
        i_req_i = 0; d_req_i = 0;
        tick;

        // asynchronous reset in the middle of a BUSY phase
        i_req_i = 1; i_addr_i = 32'h7000;
        for (int c = 0; c < 5; c++) tick;
        chk("t5_pre_en", mem_enable_o, 1);
        chk("t5_pre_to", timeout_o, 1);
        #2;
        rst_i = 1'b1;
        #1;
        chk("t5_en", mem_enable_o, 0);
        chk("t5_gnt", grant_o, 0);
        chk("t5_iack", i_ack_o, 0);
        chk("t5_dack", d_ack_o, 0);
        chk("t5_to", timeout_o, 0);
        i_req_i = 0;
        @(negedge clk_i);
        rst_i = 1'b0;
        tick;
        chk("t5_idle", grant_o, 0);

        // memory stalls past TIMEOUT_CYCLES, then finally answers
        d_req_i = 1; d_write_i = 0; d_addr_i = 32'h8000;
        tick;
        chk("t6_gnt", grant_o, 2'b10);
        for (int c = 1; c <= 12; c++) begin
            if (c == 8) chk("t6_to_c8", timeout_o, 0);
            if (c == 9) chk("t6_to_c9", timeout_o, 1);
            if (c < 12) tick;
        end
        chk("t6_to_c12", timeout_o, 1);
        chk("t6_en_c12", mem_enable_o, 1);
        mem_ack_i = 1; mem_data_i = 256'h77;
        tick;
        mem_ack_i = 0;
        chk("t6_dack", d_ack_o, 1);
        chk("t6_ddata", d_data_o, 256'h77);
        d_req_i = 0;
        tick;
        chk("t6_dack_pulse", d_ack_o, 0);
        chk("t6_to_sticky", timeout_o, 1);

        // stray ack while idle
        mem_ack_i = 1;
        tick;
        mem_ack_i = 0;
        chk("t7_en", mem_enable_o, 0);
        chk("t7_iack", i_ack_o, 0);
        chk("t7_dack", d_ack_o, 0);
        tick;
        chk("t7_iack2", i_ack_o, 0);
        chk("t7_dack2", d_ack_o, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
